// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter sharing one PicoRV32 native memory port: one outstanding
// transfer, one idle cycle between transfers, and a watchdog for hung transfers.
module picorv32_mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        timeout_err
);

  localparam int WDOG_BITS = $clog2(64'(TIMEOUT) + 64'd1);
  localparam int WDOG_W    = (TIMEOUT == 0) ? 1 : ((WDOG_BITS > 32) ? 32 : WDOG_BITS);
  localparam bit WDOG_EN   = (TIMEOUT != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              s_valid_q, s_valid_d;
  logic              s_instr_q, s_instr_d;
  logic [31:0]       s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic [3:0]        s_wstrb_q, s_wstrb_d;
  logic              timeout_err_q, timeout_err_d;

  logic [1:0]        req_valid;
  logic [1:0]        req_instr;
  logic [31:0]       req_addr  [2];
  logic [31:0]       req_wdata [2];
  logic [3:0]        req_wstrb [2];
  logic              winner;
  logic [1:0]        ready_vec;
  logic [1:0]        ready_out;
  logic [31:0]       rdata_mux;

  assign req_valid    = {m1_mem_valid, m0_mem_valid};
  assign req_instr    = {m1_mem_instr, m0_mem_instr};
  assign req_addr[0]  = m0_mem_addr;
  assign req_addr[1]  = m1_mem_addr;
  assign req_wdata[0] = m0_mem_wdata;
  assign req_wdata[1] = m1_mem_wdata;
  assign req_wstrb[0] = m0_mem_wstrb;
  assign req_wstrb[1] = m1_mem_wstrb;

  // On a tie, round-robin hands the port to whoever did not win last time.
  always_comb begin
    if (req_valid == 2'b11) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      winner = ~req_valid[0];
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    wdog_d        = wdog_q;
    s_valid_d     = s_valid_q;
    s_instr_d     = s_instr_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_wstrb_d     = s_wstrb_q;
    timeout_err_d = timeout_err_q;
    ready_vec     = 2'b00;
    rdata_mux     = s_mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          owner_d      = winner;
          last_grant_d = winner;
          s_valid_d    = 1'b1;
          s_instr_d    = req_instr[winner];
          s_addr_d     = req_addr[winner];
          s_wdata_d    = req_wdata[winner];
          s_wstrb_d    = req_wstrb[winner];
          wdog_d       = '0;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A real completion beats a watchdog expiry landing in the same cycle.
        if (s_mem_ready) begin
          ready_vec[owner_q] = 1'b1;
          s_valid_d          = 1'b0;
          wdog_d             = '0;
          state_d            = ST_GAP;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          ready_vec[owner_q] = 1'b1;
          rdata_mux          = ERR_RDATA;
          timeout_err_d      = 1'b1;
          s_valid_d          = 1'b0;
          wdog_d             = '0;
          state_d            = ST_GAP;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      wdog_q        <= '0;
      s_valid_q     <= 1'b0;
      s_instr_q     <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_wstrb_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      wdog_q        <= wdog_d;
      s_valid_q     <= s_valid_d;
      s_instr_q     <= s_instr_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_wstrb_q     <= s_wstrb_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // A transfer cut short by reset must never report completion.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_out[gi] = ready_vec[gi] & ~reset;
  end

  assign m0_mem_ready = ready_out[0];
  assign m1_mem_ready = ready_out[1];
  assign m0_mem_rdata = rdata_mux;
  assign m1_mem_rdata = rdata_mux;
  assign s_mem_valid  = s_valid_q;
  assign s_mem_instr  = s_instr_q;
  assign s_mem_addr   = s_addr_q;
  assign s_mem_wdata  = s_wdata_q;
  assign s_mem_wstrb  = s_wstrb_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: two instances (round-robin TIMEOUT=8, fixed-priority
// TIMEOUT=5), directed scenarios with literal expectations, then randomized traffic.
module tb_picorv32_mem_arbiter;

  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam int PH_IDLE = 0, PH_BUSY = 1, PH_GAP = 2;

  logic clk;
  logic rst;

  logic [1:0]  mv [2];
  logic [1:0]  mi [2];
  logic [31:0] ma [2][2];
  logic [31:0] mw [2][2];
  logic [3:0]  ms [2][2];
  logic        sr  [2] = '{1'b0, 1'b0};
  logic [31:0] srd [2] = '{32'd0, 32'd0};

  wire [1:0]  mr  [2];
  wire [31:0] mrd [2][2];
  wire        sv  [2];
  wire        si  [2];
  wire [31:0] sa  [2];
  wire [31:0] sw  [2];
  wire [3:0]  ss  [2];
  wire        terr [2];

  int          ds_mode  [2];
  int          ds_lat   [2];
  logic [31:0] ds_rdata [2];
  bit          ds_pulse [2];
  int          age_r    [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  int q0_who[$], q0_cyc[$], q1_who[$], q1_cyc[$];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    picorv32_mem_arbiter #(
      .FIXED_PRIO(gi),
      .TIMEOUT(gi == 0 ? 8 : 5),
      .ERR_RDATA(32'hDEADBEEF)
    ) u_dut (
      .clk(clk), .reset(rst),
      .m0_mem_valid(mv[gi][0]), .m0_mem_instr(mi[gi][0]), .m0_mem_addr(ma[gi][0]),
      .m0_mem_wdata(mw[gi][0]), .m0_mem_wstrb(ms[gi][0]),
      .m0_mem_ready(mr[gi][0]), .m0_mem_rdata(mrd[gi][0]),
      .m1_mem_valid(mv[gi][1]), .m1_mem_instr(mi[gi][1]), .m1_mem_addr(ma[gi][1]),
      .m1_mem_wdata(mw[gi][1]), .m1_mem_wstrb(ms[gi][1]),
      .m1_mem_ready(mr[gi][1]), .m1_mem_rdata(mrd[gi][1]),
      .s_mem_valid(sv[gi]), .s_mem_instr(si[gi]), .s_mem_addr(sa[gi]),
      .s_mem_wdata(sw[gi]), .s_mem_wstrb(ss[gi]),
      .s_mem_ready(sr[gi]), .s_mem_rdata(srd[gi]),
      .timeout_err(terr[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_of(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  // Arbitration rule: lone requester wins; on a tie inst 1 (fixed) picks m0, RR picks not-last.
  function automatic int pick(input int i, input logic [1:0] v, input int last);
    if (v == 2'b11) return (i == 1) ? 0 : 1 - last;
    return (v == 2'b10) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, inst, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: transfer phase, owner, busy-cycle age (1-based), sticky error.
  int          e_phase [2];
  int          e_owner [2];
  int          e_last  [2];
  int          e_age   [2];
  bit          e_err   [2];
  bit          e_sv    [2];
  bit          e_si    [2];
  logic [31:0] e_sa    [2];
  logic [31:0] e_sw    [2];
  logic [3:0]  e_ss    [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        e_phase[i] <= PH_IDLE; e_owner[i] <= 0; e_last[i] <= 1; e_age[i] <= 0;
        e_err[i] <= 1'b0; e_sv[i] <= 1'b0; e_si[i] <= 1'b0;
        e_sa[i] <= '0; e_sw[i] <= '0; e_ss[i] <= '0;
      end else if (e_phase[i] == PH_IDLE) begin
        if (mv[i] != 2'b00) begin
          e_owner[i] <= pick(i, mv[i], e_last[i]);
          e_last[i]  <= pick(i, mv[i], e_last[i]);
          e_si[i]    <= mi[i][pick(i, mv[i], e_last[i])];
          e_sa[i]    <= ma[i][pick(i, mv[i], e_last[i])];
          e_sw[i]    <= mw[i][pick(i, mv[i], e_last[i])];
          e_ss[i]    <= ms[i][pick(i, mv[i], e_last[i])];
          e_sv[i]    <= 1'b1;
          e_age[i]   <= 1;
          e_phase[i] <= PH_BUSY;
        end
      end else if (e_phase[i] == PH_BUSY) begin
        if (sr[i] || e_age[i] == to_of(i)) begin
          if (!sr[i]) e_err[i] <= 1'b1;
          e_sv[i]    <= 1'b0;
          e_phase[i] <= PH_GAP;
        end else begin
          e_age[i] <= e_age[i] + 1;
        end
      end else begin
        e_phase[i] <= PH_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [1:0]  er;
        logic [31:0] erd;
        er  = 2'b00;
        erd = srd[i];
        if (!rst && e_phase[i] == PH_BUSY) begin
          if (sr[i]) begin
            er[e_owner[i]] = 1'b1;
          end else if (e_age[i] == to_of(i)) begin
            er[e_owner[i]] = 1'b1;
            erd = ERR;
          end
        end
        check("s_valid", i, 32'(sv[i]), 32'(e_sv[i]));
        check("s_instr", i, 32'(si[i]), 32'(e_si[i]));
        check("s_addr", i, sa[i], e_sa[i]);
        check("s_wdata", i, sw[i], e_sw[i]);
        check("s_wstrb", i, 32'(ss[i]), 32'(e_ss[i]));
        check("timeout_err", i, 32'(terr[i]), 32'(e_err[i]));
        for (int j = 0; j < 2; j++) begin
          check((j == 0) ? "m0_ready" : "m1_ready", i, 32'(mr[i][j]), 32'(er[j]));
          if (er[j]) check((j == 0) ? "m0_rdata" : "m1_rdata", i, mrd[i][j], erd);
        end
      end
    end
  end

  // Downstream responder: 0 silent, 1 fixed latency, 2 random (including stray readies).
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (sv[i]) age_r[i] = age_r[i] + 1;
      else age_r[i] = 0;
      case (ds_mode[i])
        1: sr[i] = sv[i] && (age_r[i] == ds_lat[i]);
        2: sr[i] = sv[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        default: sr[i] = 1'b0;
      endcase
      if (ds_pulse[i]) sr[i] = 1'b1;
      srd[i] = (sr[i] && ds_mode[i] == 1) ? ds_rdata[i] : $urandom;
    end
  end

  task automatic collect(input int n);
    q0_who.delete(); q0_cyc.delete(); q1_who.delete(); q1_cyc.delete();
    for (int c = 1; c <= n; c++) begin
      step();
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (mr[0][j]) begin q0_who.push_back(j); q0_cyc.push_back(c); end
        if (mr[1][j]) begin q1_who.push_back(j); q1_cyc.push_back(c); end
      end
    end
  endtask

  initial begin
    int got, cyc, nb, pulses, m1seen, r;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 2'b00; mi[i] = 2'b00;
      ds_mode[i] = 0; ds_lat[i] = 1; ds_rdata[i] = '0; ds_pulse[i] = 1'b0; age_r[i] = 0;
      for (int j = 0; j < 2; j++) begin ma[i][j] = '0; mw[i][j] = '0; ms[i][j] = '0; end
    end
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_valid", 0, 32'(sv[0]), 0);
    check("rst_s_addr", 0, sa[0], 0);
    check("rst_timeout_err", 1, 32'(terr[1]), 0);

    // Single read by m0, downstream answers on its third busy cycle.
    ds_mode[0] = 1; ds_lat[0] = 3; ds_rdata[0] = 32'h12345678;
    step();
    mv[0] = 2'b01; ma[0][0] = 32'h100; ms[0][0] = 4'b0000; mi[0][0] = 1'b0;
    got = 0; cyc = 0; pulses = 0; m1seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (got != 0) mv[0] = 2'b00;
      @(negedge clk);
      cyc++;
      if (mr[0][1]) m1seen = 1;
      if (mr[0][0]) begin
        pulses++;
        if (got == 0) begin
          check("t1_rdata", 0, mrd[0][0], 32'h12345678);
          check("t1_latency", 0, 32'(cyc), 3);
        end
        got = 1;
      end
    end
    check("t1_pulses", 0, 32'(pulses), 1);
    check("t1_m1_ready", 0, 32'(m1seen), 0);

    // Both requesters hold valid after reset: RR alternates, fixed priority keeps m0.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    mv[0] = 2'b11; mv[1] = 2'b11;
    ma[0][0] = 32'hA0; ma[0][1] = 32'hB0; ma[1][0] = 32'hA0; ma[1][1] = 32'hB0;
    ds_mode[0] = 1; ds_lat[0] = 2; ds_mode[1] = 1; ds_lat[1] = 2;
    collect(20);
    check("t2_count", 0, 32'(q0_who.size() >= 4), 1);
    check("t3_count", 1, 32'(q1_who.size() >= 3), 1);
    if (q0_cyc.size() > 0) check("t2_first_cycle", 0, 32'(q0_cyc[0]), 2);
    for (int k = 0; k < 4 && k < q0_who.size(); k++)
      check("t2_order", 0, 32'(q0_who[k]), 32'(k % 2));
    for (int k = 0; k < 3 && k + 1 < q0_cyc.size(); k++)
      check("t2_spacing", 0, 32'(q0_cyc[k+1] - q0_cyc[k]), 4);
    for (int k = 0; k < 3 && k < q1_who.size(); k++)
      check("t3_order", 1, 32'(q1_who[k]), 0);
    step(); mv[0] = 2'b00; mv[1] = 2'b00;
    repeat (8) step();

    // m1 write; payload on s_* must stay frozen while m1 scribbles on its inputs.
    ds_mode[0] = 1; ds_lat[0] = 4; ds_rdata[0] = 32'h0000C0DE;
    step();
    mv[0] = 2'b10; ma[0][1] = 32'h2000; mw[0][1] = 32'hA5A5A5A5; ms[0][1] = 4'b0110;
    mi[0][1] = 1'b0;
    got = 0; nb = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (got != 0) mv[0] = 2'b00;
      else begin
        ma[0][1] = $urandom; mw[0][1] = $urandom; ms[0][1] = 4'($urandom); mi[0][1] = 1'($urandom);
      end
      @(negedge clk);
      if (sv[0]) begin
        nb++;
        check("t4_addr", 0, sa[0], 32'h2000);
        check("t4_wdata", 0, sw[0], 32'hA5A5A5A5);
        check("t4_wstrb", 0, 32'(ss[0]), 32'h6);
        check("t4_instr", 0, 32'(si[0]), 0);
      end
      if (mr[0][1]) got = 1;
    end
    check("t4_done", 0, 32'(got), 1);
    check("t4_busy_cycles", 0, 32'(nb), 4);

    // Silent downstream: watchdog answers on the 8th busy cycle, error stays sticky.
    ds_mode[0] = 0;
    step();
    mv[0] = 2'b01; ma[0][0] = 32'h300; ms[0][0] = 4'b0000;
    got = 0; cyc = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (got != 0) mv[0] = 2'b00;
      @(negedge clk);
      cyc++;
      if (mr[0][0] && got == 0) begin
        check("t5_err_rdata", 0, mrd[0][0], ERR);
        check("t5_latency", 0, 32'(cyc), 8);
        got = 1;
      end
    end
    check("t5_done", 0, 32'(got), 1);
    check("t5_sticky", 0, 32'(terr[0]), 1);
    ds_mode[0] = 1; ds_lat[0] = 2; ds_rdata[0] = 32'h55AA1234;
    step();
    mv[0] = 2'b01;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (got != 0) mv[0] = 2'b00;
      @(negedge clk);
      if (mr[0][0] && got == 0) begin
        check("t5_next_rdata", 0, mrd[0][0], 32'h55AA1234);
        got = 1;
      end
    end
    check("t5_next_done", 0, 32'(got), 1);
    check("t5_still_sticky", 0, 32'(terr[0]), 1);

    // Reset in the middle of a transfer, with downstream readies around it.
    ds_mode[0] = 0;
    step(); mv[0] = 2'b01;
    step();
    step(); rst = 1'b1; ds_pulse[0] = 1'b1;
    @(negedge clk);
    check("t6_no_ready_in_reset", 0, 32'(mr[0]), 0);
    step(); rst = 1'b0; mv[0] = 2'b00;
    @(negedge clk);
    check("t6_s_valid", 0, 32'(sv[0]), 0);
    check("t6_late_ready", 0, 32'(mr[0]), 0);
    check("t6_err_cleared", 0, 32'(terr[0]), 0);
    step(); ds_pulse[0] = 1'b0;

    // Randomized traffic on both instances.
    ds_mode[0] = 2; ds_mode[1] = 2;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 29) == 0) begin
          r = $urandom_range(0, 9);
          ds_mode[i]  = (r < 2) ? 0 : ((r < 5) ? 1 : 2);
          ds_lat[i]   = $urandom_range(1, 6);
          ds_rdata[i] = $urandom;
        end
        for (int j = 0; j < 2; j++) begin
          mv[i][j] = ($urandom_range(0, 99) < 55);
          mi[i][j] = 1'($urandom);
          ma[i][j] = $urandom;
          mw[i][j] = $urandom;
          ms[i][j] = 4'($urandom);
        end
      end
    end
    step();
    rst = 1'b0; mv[0] = 2'b00; mv[1] = 2'b00;
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
